dog_window_generator: RTL and testbench

//  Forms the 3x3x3 scale-space neighbourhood consumed by the extremum detector.

---
 rtl/dog_window_generator_pkg.sv | 22 ++
 rtl/dog_window_generator_if.sv | 26 ++
 rtl/dog_line_buffer.sv | 32 +++
 rtl/dog_window_generator.sv | 117 +++++++++++
 tb/tb_dog_window_generator.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/dog_window_generator_pkg.sv
// Shared defaults, FSM encoding and neighbour indexing for the DoG window generator.
package dog_window_generator_pkg;

  localparam int unsigned DW_DEF         = 8;
  localparam int unsigned IMG_WIDTH_DEF  = 640;
  localparam int unsigned IMG_HEIGHT_DEF = 480;
  localparam int unsigned N_LAYERS       = 3;
  localparam int unsigned N_NBR          = 27;

  // FILL: rows 0-1 of a frame, window cannot be complete; RUN: rows 2..end.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Neighbour slot for layer k, window row r (0 = y-2), window column c (0 = x-2).
  function automatic int unsigned nbrIdx(input int unsigned k, input int unsigned r,
                                         input int unsigned c);
    return 9 * k + 3 * r + c;
  endfunction

endpackage

// File: rtl/dog_window_generator_if.sv
// Pixel-stream input and 3x3x3 window output bundle.
interface dog_window_generator_if
  import dog_window_generator_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);

  logic          iDval;
  logic [DW-1:0] iData_l0;
  logic [DW-1:0] iData_l1;
  logic [DW-1:0] iData_l2;
  logic          oDval;
  logic [DW-1:0] oData_a;
  logic [DW-1:0] oData_b [N_NBR];

  modport master (
    output iDval, iData_l0, iData_l1, iData_l2,
    input  oDval, oData_a, oData_b
  );

  modport slave (
    input  iDval, iData_l0, iData_l1, iData_l2,
    output oDval, oData_a, oData_b
  );

endinterface

// File: rtl/dog_line_buffer.sv
// Two-line delay for one layer: d1 is row y-1 and d2 is row y-2 at the input column.
module dog_line_buffer #(
  parameter int unsigned DW        = 8,
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned AW        = $clog2(IMG_WIDTH)
) (
  input  logic          iclk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] d1,
  output logic [DW-1:0] d2
);

  logic [DW-1:0] line1 [IMG_WIDTH];
  logic [DW-1:0] line2 [IMG_WIDTH];

  // Read the column before it is overwritten so taps stay aligned with din.
  always_comb begin
    d1 = line1[addr];
    d2 = line2[addr];
  end

  // Cascade: the current pixel enters line1, the displaced row-above pixel moves to line2.
  always_ff @(posedge iclk) begin
    if (en) begin
      line1[addr] <= din;
      line2[addr] <= line1[addr];
    end
  end

endmodule

// File: rtl/dog_window_generator.sv
// Builds the 3x3x3 scale-space neighbourhood from three aligned DoG layer streams.
module dog_window_generator
  import dog_window_generator_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input logic                   iclk,
  input logic                   irst_n,
  dog_window_generator_if.slave bus
);

  localparam int unsigned   XW    = $clog2(IMG_WIDTH);
  localparam int unsigned   YW    = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] XLAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YLAST = YW'(IMG_HEIGHT - 1);

  state_t        state;
  logic [XW-1:0] xCnt;
  logic [YW-1:0] yCnt;
  logic          winValid;
  logic [DW-1:0] pix     [N_LAYERS];
  logic [DW-1:0] tap1    [N_LAYERS];
  logic [DW-1:0] tap2    [N_LAYERS];
  logic [DW-1:0] win     [N_LAYERS][3][3];
  logic [DW-1:0] winNext [N_LAYERS][3][3];

  // Gather the layer inputs so the per-layer logic can be written as loops.
  always_comb begin
    pix[0] = bus.iData_l0;
    pix[1] = bus.iData_l1;
    pix[2] = bus.iData_l2;
  end

  for (genvar k = 0; k < N_LAYERS; k++) begin : gLayer
    dog_line_buffer #(
      .DW        (DW),
      .IMG_WIDTH (IMG_WIDTH),
      .AW        (XW)
    ) uLineBuf (
      .iclk (iclk),
      .en   (bus.iDval),
      .addr (xCnt),
      .din  (pix[k]),
      .d1   (tap1[k]),
      .d2   (tap2[k])
    );
  end

  // Window after this beat's shift; the output stage samples it directly so data
  // lands one cycle after the beat rather than two.
  always_comb begin
    for (int unsigned k = 0; k < N_LAYERS; k++) begin
      for (int unsigned r = 0; r < 3; r++) begin
        winNext[k][r][0] = win[k][r][1];
        winNext[k][r][1] = win[k][r][2];
      end
      winNext[k][0][2] = tap2[k];
      winNext[k][1][2] = tap1[k];
      winNext[k][2][2] = pix[k];
    end
  end

  // A window is complete once two rows and two columns of the line are behind us.
  always_comb begin
    winValid = bus.iDval && (state == RUN) && (xCnt >= XW'(2));
  end

  // Window register banks: shift left one column per accepted beat.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int unsigned k = 0; k < N_LAYERS; k++)
        for (int unsigned r = 0; r < 3; r++)
          for (int unsigned c = 0; c < 3; c++)
            win[k][r][c] <= '0;
    end else if (bus.iDval) begin
      win <= winNext;
    end
  end

  // Raster counters, FILL/RUN sequencing and the registered window outputs.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      xCnt        <= '0;
      yCnt        <= '0;
      state       <= FILL;
      bus.oDval   <= 1'b0;
      bus.oData_a <= '0;
      for (int unsigned i = 0; i < N_NBR; i++) bus.oData_b[i] <= '0;
    end else begin
      bus.oDval <= winValid;
      if (winValid) begin
        bus.oData_a <= winNext[1][1][1];
        for (int unsigned k = 0; k < N_LAYERS; k++)
          for (int unsigned r = 0; r < 3; r++)
            for (int unsigned c = 0; c < 3; c++)
              bus.oData_b[nbrIdx(k, r, c)] <= winNext[k][r][c];
      end
      if (bus.iDval) begin
        if (xCnt == XLAST) begin
          xCnt <= '0;
          if (yCnt == YLAST) begin
            yCnt  <= '0;
            state <= FILL;
          end else begin
            yCnt <= yCnt + 1'b1;
            if (yCnt == YW'(1)) state <= RUN;
          end
        end else begin
          xCnt <= xCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dog_window_generator.sv
// Directed bench for dog_window_generator on an 8x6 frame.
module tb_dog_window_generator;
  import dog_window_generator_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic iclk   = 1'b0;
  logic irst_n = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;

  logic [7:0] lastA;
  logic [7:0] lastB0;
  logic [7:0] lastB26;

  dog_window_generator_if #(.DW(8)) bus ();

  dog_window_generator #(
    .DW         (8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (bus)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] px(input int k, input int x, input int y, input int off,
                                    input bit cst);
    if (cst) return 8'd200;
    return 8'(k * 64 + y * W + x + off);
  endfunction

  task automatic drive(input logic v, input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] p2);
    bus.iDval    = v;
    bus.iData_l0 = p0;
    bus.iData_l1 = p1;
    bus.iData_l2 = p2;
    @(posedge iclk);
    #1;
  endtask

  task automatic chkHeld(input string tag);
    chk({tag, " dval"}, {31'd0, bus.oDval}, 32'd0);
    chk({tag, " hold a"}, {24'd0, bus.oData_a}, {24'd0, lastA});
    chk({tag, " hold b0"}, {24'd0, bus.oData_b[0]}, {24'd0, lastB0});
    chk({tag, " hold b26"}, {24'd0, bus.oData_b[26]}, {24'd0, lastB26});
  endtask

  // Streams one frame (maxBeats > 0 stops early) and checks every output cycle.
  task automatic runFrame(input string name, input int off, input bit cst, input int gapPct,
                          input int maxBeats);
    int beatIdx = 0;
    int wins    = 0;
    int first   = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (maxBeats > 0 && beatIdx == maxBeats) return;
        while (gapPct > 0 && $urandom_range(99, 0) < gapPct) begin
          drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
          chkHeld({name, " idle"});
        end
        drive(1'b1, px(0, x, y, off, cst), px(1, x, y, off, cst), px(2, x, y, off, cst));
        beatIdx++;
        if (x >= 2 && y >= 2) begin
          wins++;
          if (first == 0) first = beatIdx;
          chk({name, " dval"}, {31'd0, bus.oDval}, 32'd1);
          chk({name, " a"}, {24'd0, bus.oData_a}, {24'd0, px(1, x - 1, y - 1, off, cst)});
          for (int unsigned k = 0; k < 3; k++)
            for (int unsigned r = 0; r < 3; r++)
              for (int unsigned c = 0; c < 3; c++)
                chk($sformatf("%s b%0d", name, nbrIdx(k, r, c)),
                    {24'd0, bus.oData_b[nbrIdx(k, r, c)]},
                    {24'd0, px(int'(k), x - 2 + int'(c), y - 2 + int'(r), off, cst)});
          if (!cst && off == 0 && wins == 1) begin
            chk({name, " first a"}, {24'd0, bus.oData_a}, 32'd73);
            chk({name, " first b0"}, {24'd0, bus.oData_b[0]}, 32'd0);
            chk({name, " first b13"}, {24'd0, bus.oData_b[13]}, 32'd73);
            chk({name, " first b26"}, {24'd0, bus.oData_b[26]}, 32'd146);
          end
          if (!cst && off == 1 && wins == 1)
            chk({name, " first a"}, {24'd0, bus.oData_a}, 32'd74);
          if (!cst && off == 0 && wins == 24)
            chk({name, " last a"}, {24'd0, bus.oData_a}, 32'd102);
          lastA   = px(1, x - 1, y - 1, off, cst);
          lastB0  = px(0, x - 2, y - 2, off, cst);
          lastB26 = px(2, x, y, off, cst);
        end else begin
          chkHeld(name);
        end
      end
    end
    chk({name, " windows"}, wins, 32'd24);
    chk({name, " first beat"}, first, 32'd19);
  endtask

  initial begin
    bus.iDval    = 1'b0;
    bus.iData_l0 = '0;
    bus.iData_l1 = '0;
    bus.iData_l2 = '0;
    irst_n       = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    chk("reset dval", {31'd0, bus.oDval}, 32'd0);
    chk("reset a", {24'd0, bus.oData_a}, 32'd0);
    chk("reset b0", {24'd0, bus.oData_b[0]}, 32'd0);
    chk("reset b13", {24'd0, bus.oData_b[13]}, 32'd0);
    chk("reset b26", {24'd0, bus.oData_b[26]}, 32'd0);
    irst_n  = 1'b1;
    lastA   = '0;
    lastB0  = '0;
    lastB26 = '0;

    runFrame("ramp", 0, 1'b0, 0, 0);
    runFrame("gaps", 0, 1'b0, 40, 0);
    runFrame("f1", 0, 1'b0, 0, 0);
    runFrame("f2", 1, 1'b0, 0, 0);

    // Stop on beat (3,3), then reset asynchronously between clock edges.
    runFrame("pre", 0, 1'b0, 0, 28);
    bus.iDval = 1'b0;
    #2 irst_n = 1'b0;
    #1;
    chk("midrst dval", {31'd0, bus.oDval}, 32'd0);
    chk("midrst a", {24'd0, bus.oData_a}, 32'd0);
    for (int i = 0; i < 27; i++)
      chk($sformatf("midrst b%0d", i), {24'd0, bus.oData_b[i]}, 32'd0);
    lastA   = '0;
    lastB0  = '0;
    lastB26 = '0;
    @(posedge iclk);
    #1 irst_n = 1'b1;

    runFrame("fresh", 0, 1'b0, 0, 0);
    runFrame("const", 0, 1'b1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
